// File: rtl/inv_sub_bytes_unit_pkg.sv
`default_nettype none
// ============================================================================
// inv_sub_bytes_unit_pkg : shared types, widths and inverse S-box lookup
// Revision : 1.0
// ============================================================================
package inv_sub_bytes_unit_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int WORD_CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry for byte value v sits at bits [2047-8v -: 8] (row 0 first).
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] value);
    logic [10:0] idx;
    idx = {~value, 3'b000};
    return INV_SBOX_TABLE[idx +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sub_bytes_unit_inv_sub_box.sv
`default_nettype none
// ============================================================================
// inv_sub_bytes_unit_inv_sub_box : combinational 32-bit inverse S-box (4 bytes)
// Revision : 1.0
// ============================================================================
module inv_sub_bytes_unit_inv_sub_box
  import inv_sub_bytes_unit_pkg::*;
(
  input  logic [AES_WORD_W-1:0] state_word,
  output logic [AES_WORD_W-1:0] sub_word
);

  for (genvar i = 0; i < AES_WORD_W / 8; i++) begin : g_byte
    assign sub_word[8*i +: 8] = inv_sbox(state_word[8*i +: 8]);
  end

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_unit.sv
`default_nettype none
// ============================================================================
// inv_sub_bytes_unit : AES InvSubBytes with valid/ready handshake; word-serial
// by default, 16 parallel lookups when INV_SUB_BYTES_PARALLEL_EN is defined.
// Revision : 1.0
// ============================================================================
module inv_sub_bytes_unit
  import inv_sub_bytes_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [AES_STATE_W-1:0] inState,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [AES_STATE_W-1:0] outState
);

  state_t                 state;
  state_t                 state_nxt;
  logic [AES_STATE_W-1:0] captured;
  logic [AES_STATE_W-1:0] result;
  logic                   accept;
  logic                   last_word;

  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        // A consumed result frees the slot in the same cycle.
        inReady = outReady;
        if (outReady) state_nxt = inValid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = inValid & inReady;
  assign outValid = (state == DONE);
  assign outState = result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      captured <= '0;
    end else begin
      state <= state_nxt;
      if (accept) captured <= inState;
    end
  end

`ifdef INV_SUB_BYTES_PARALLEL_EN

  logic [AES_STATE_W-1:0] sub_state;

  for (genvar i = 0; i < AES_STATE_W / AES_WORD_W; i++) begin : g_lane
    inv_sub_bytes_unit_inv_sub_box u_box (
      .state_word (captured[AES_WORD_W*i +: AES_WORD_W]),
      .sub_word   (sub_state[AES_WORD_W*i +: AES_WORD_W])
    );
  end

  assign last_word = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (state == BUSY) begin
      result <= sub_state;
    end
  end

`else

  logic [WORD_CNT_W-1:0]             word_cnt;
  logic [AES_WORD_W-1:0]             cur_word;
  logic [AES_WORD_W-1:0]             sub_word;
  // Words 0..2 are staged here so outState only changes once all four are ready.
  logic [AES_STATE_W-AES_WORD_W-1:0] partial;

  always_comb begin
    cur_word = captured[127:96];
    case (word_cnt)
      2'd0:    cur_word = captured[127:96];
      2'd1:    cur_word = captured[95:64];
      2'd2:    cur_word = captured[63:32];
      2'd3:    cur_word = captured[31:0];
      default: cur_word = captured[127:96];
    endcase
  end

  inv_sub_bytes_unit_inv_sub_box u_box (
    .state_word (cur_word),
    .sub_word   (sub_word)
  );

  assign last_word = (word_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      partial  <= '0;
      result   <= '0;
    end else begin
      if (accept) begin
        word_cnt <= '0;
      end else if (state == BUSY) begin
        word_cnt <= word_cnt + WORD_CNT_W'(1);
      end
      if (state == BUSY) begin
        case (word_cnt)
          2'd0:    partial[95:64] <= sub_word;
          2'd1:    partial[63:32] <= sub_word;
          2'd2:    partial[31:0]  <= sub_word;
          2'd3:    result         <= {partial, sub_word};
          default: partial        <= partial;
        endcase
      end
    end
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_unit.sv
`default_nettype none
// ============================================================================
// tb_inv_sub_bytes_unit : scoreboard bench, reference inverse S-box derived
// from GF(2^8) inversion and the AES affine map. Revision : 1.0
// ============================================================================
module tb_inv_sub_bytes_unit;

`ifdef INV_SUB_BYTES_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  logic         clk;
  logic         rst_n;
  logic         inValid;
  logic         inReady;
  logic [127:0] inState;
  logic         outValid;
  logic         outReady;
  logic [127:0] outState;

  inv_sub_bytes_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inState  (inState),
    .outValid (outValid),
    .outReady (outReady),
    .outState (outState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           cycles = 0;
  int           last_accept_edge = 0;
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];
  int           lat_q [$];
  logic [127:0] last_out = '0;
  logic         prev_valid = 1'b0;
  logic         rand_ready = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [7:0] r;
    r = (b << k) | (b >> (8 - k));
    return r;
  endfunction

  // Forward S-box = affine(GF inverse); inverse table is its permutation inverse.
  task automatic build_tables();
    logic [7:0] x, inv, s;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      if (i != 0)
        for (int j = 1; j < 256; j++)
          if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cycles++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) outReady = 1'($urandom_range(0, 1));
  end

  // Accept monitor: push the expected result and the accept edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && inValid && inReady) begin
      exp_q.push_back(ref_inv(inState));
      lat_q.push_back(cycles + 1);
      last_accept_edge = cycles + 1;
    end
  end

  // Output monitor.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (outValid && !prev_valid) begin
        if (lat_q.size() == 0) fail_now("unexpected outValid");
        else chk("latency", 128'(cycles - lat_q.pop_front()), 128'(LAT));
      end
      prev_valid = outValid;
      if (outValid) begin
        chk("inReady follows outReady", 128'(inReady), 128'(outReady));
        if (exp_q.size() == 0) begin
          fail_now("result without transaction");
        end else begin
          chk("outState", outState, exp_q[0]);
          if (outReady) last_out = exp_q.pop_front();
        end
      end else begin
        chk("outState hold", outState, last_out);
      end
    end
  end

  task automatic wait_accept();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inReady) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("accept timeout");
  endtask

  task automatic drive_accept(input logic [127:0] d);
    inState = d;
    inValid = 1'b1;
    wait_accept();
  endtask

  task automatic send(input logic [127:0] d);
    @(posedge clk);
    #1;
    drive_accept(d);
    inValid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (outValid) return;
    end
    fail_now("outValid timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !outValid) return;
    end
    fail_now("drain timeout");
  endtask

  task automatic send_known(input string name, input logic [127:0] d, input logic [127:0] want);
    send(d);
    wait_valid();
    chk(name, outState, want);
    wait_drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b;
    int           ea;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inState  = '0;
    outReady = 1'b0;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    chk("reset outValid", 128'(outValid), 128'(0));
    chk("reset outState", outState, '0);
    rst_n = 1'b1;
    #1;
    chk("reset inReady", 128'(inReady), 128'(1));
    outReady = 1'b1;

    send_known("identity row", 128'h637c777b_f26b6fc5_3001672b_fed7ab76,
               128'h00010203_04050607_08090a0b_0c0d0e0f);
    send_known("bytes 16", {16{8'h16}}, {16{8'hff}});
    send_known("bytes 00", {16{8'h00}}, {16{8'h52}});
    send_known("bytes 52", {16{8'h52}}, {16{8'h48}});

    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      send({$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Back-pressure with a pending input.
    outReady = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    send(a);
    wait_valid();
    @(posedge clk);
    #1;
    inState = b;
    inValid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    outReady = 1'b1;
    wait_accept();
    inValid = 1'b0;
    wait_drain();

    // Back-to-back with inValid held high.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    drive_accept(a);
    ea = last_accept_edge;
    drive_accept(b);
    chk("b2b capture edge", 128'(last_accept_edge - ea), 128'(LAT + 1));
    inValid = 1'b0;
    wait_drain();

    // Reset while word 2 is being processed.
    send({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    last_out = '0;
    #1;
    chk("async reset outValid", 128'(outValid), 128'(0));
    chk("async reset outState", outState, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send({$urandom, $urandom, $urandom, $urandom});
    wait_drain();

    // Input disturbance during BUSY.
    send({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 20 && !outValid; i++) begin
      inState = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_unit.md
INV_SUB_BYTES_UNIT -- requirements
Module: inv_sub_bytes_unit

Interface
- REQ-001 Parameters: none.
- REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
- REQ-003 rst_n  input  1  Asynchronous, active-low reset.
- REQ-004 inValid  input  1  inState is valid.
- REQ-005 inReady  output  1  Block accepts inState this cycle.
- REQ-006 inState  input  128  AES state to transform. Byte 0 is bits 127:120.
- REQ-007 outValid  output  1  outState holds a completed result.
- REQ-008 outReady  input  1  Consumer accepts outState this cycle.
- REQ-009 outState  output  128  InvSubBytes of the accepted inState. Byte order is the same as inState.

Function
- REQ-010 Transform: each output byte SHALL equal the FIPS-197 inverse S-box of the input byte in the same position.
- REQ-011 States: IDLE, BUSY, DONE.
- REQ-012 IDLE behaviour:
  - inReady=1 and outValid=0.
  - inValid=1 captures inState, clears wordCnt to 0 and moves to BUSY.
- REQ-013 BUSY behaviour:
  - Exactly one 32-bit word per cycle; word wordCnt is bits 127-32*wordCnt down to 96-32*wordCnt.
  - The result word is written to the same position in the result register.
  - wordCnt increments by 1 each cycle.
  - After word 3, wordCnt wraps to 0 and the state moves to DONE.
  - inReady=0; inValid is ignored.
- REQ-014 Latency: an accept on edge T SHALL give outValid=1 after edge T+4.
- REQ-015 DONE holding: outValid=1; outState is stable until the handshake.
- REQ-016 DONE exit:
  - outValid&outReady with inValid=0: go to IDLE.
  - outValid&outReady with inValid=1: capture the new inState and go directly to BUSY, giving back-to-back throughput of one block per 5 cycles.
- REQ-017 DONE inReady: inReady SHALL equal outReady, so input is never accepted while a result is pending and unconsumed.
- REQ-018 Before completion: outState SHALL hold the previous result, or zero after reset, until DONE is entered; partial words are never presented with outValid=1.
- REQ-019 Input during BUSY: changes to inState SHALL NOT affect the result, because the captured copy is used.

Reset
- REQ-020 On rst_n=0, asynchronously:
  - state=IDLE, wordCnt=0.
  - Captured state register and outState=0.
  - outValid=0, inReady=1 once reset is released.
- REQ-021 Reset asserted during BUSY or DONE SHALL abandon the operation; no result is emitted for it.

Configuration
- REQ-022 Macro INV_SUB_BYTES_PARALLEL_EN.
- REQ-023 Defined: 16 byte lookups in parallel.
  - BUSY lasts one cycle and latency is 1 (outValid after edge T+1).
  - wordCnt is absent.
  - Throughput is one block per 2 cycles back-to-back.
- REQ-024 Undefined: the 4-cycle word-serial behaviour of REQ-013/REQ-014 applies, with a single 32-bit lookup instance. All handshake and reset rules are identical in both builds.

Structure
- REQ-025 Shared package contents:
  - State encoding typedef (IDLE/BUSY/DONE).
  - Word-count width.
  - Constant AES_STATE_W=128 and AES_WORD_W=32.
- REQ-026 One sub-module InvSubBox: a combinational 32-bit-in/32-bit-out inverse S-box of four byte lookups. The unit instantiates one of it, or four when INV_SUB_BYTES_PARALLEL_EN is defined.

Verification
- REQ-027 Identity row:
  - Stimulus: inState=637c777b_f26b6fc5_3001672b_fed7ab76.
  - Required: outState=00010203_04050607_08090a0b_0c0d0e0f, with outValid rising exactly 4 cycles after the accept (1 cycle when parallel).
- REQ-028 Boundary bytes:
  - Stimulus: inState all 0x16.
  - Required: all 0xff.
  - Then inState all 0x00 -> all 0x52; inState all 0x52 -> all 0x48.
- REQ-029 Back-pressure:
  - Stimulus: hold outReady=0 for 10 cycles after completion.
  - Required: outValid stays 1, outState is stable, inReady=0; a pending inValid is not accepted until outReady=1.
- REQ-030 Back-to-back:
  - Stimulus: outReady=1, inValid=1 continuously with two distinct states.
  - Required: the second state is captured on the output-handshake edge, and both results are correct in order.
- REQ-031 Reset mid-operation:
  - Stimulus: assert rst_n=0 in BUSY when wordCnt=2.
  - Required: outValid=0 and outState=0 immediately, without waiting for a clock edge; the next transaction gives the correct result.
- REQ-032 Input disturbance:
  - Stimulus: change inState every cycle during BUSY.
  - Required: the result matches the value captured at accept.
